test_run_controller: RTL

Synthesizable, parametrised run controller for self-checking test harnesses. Launches start pulses on CHANNELS independent units under test and waits for each done, with a per-run cycle timeout. Repeats for RUNS iterations and reports per-channel timeout flags, run/fail counters and a final pass/fail verdict. Replaces ad-hoc single-channel start/done/timeout checking in benches and on-chip self-test wrappers.

---
 rtl/test_run_controller.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/test_run_controller.sv
// Multi-channel start/done run controller: launches every channel, waits for all
// completions under a cycle timeout, repeats RUNS times and reports the verdict.
module test_run_controller #(
   parameter int CHANNELS       = 4,
   parameter int TIMEOUT_CYCLES = 105,
   parameter int RUNS           = 1,
   parameter int GAP_CYCLES     = 2,
   parameter int CNT_W          = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [CHANNELS-1:0] done,
   output logic [CHANNELS-1:0] start,
   output logic                busy,
   output logic                finished,
   output logic                pass,
   output logic [CHANNELS-1:0] timeout_flags,
   output logic [CNT_W-1:0]    run_count,
   output logic [CNT_W-1:0]    fail_count
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 2);
   localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0]    GAP_LAST   = GW'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_CHECK  = 3'd3,
      ST_GAP    = 3'd4,
      ST_FINISH = 3'd5
   } state_t;

   state_t              state_r, state_nxt_s;
   logic [CHANNELS-1:0] latch_r, latch_nxt_s, seen_s;
   logic [TW-1:0]       timer_r, timer_nxt_s;
   logic [GW-1:0]       gap_r, gap_nxt_s;
   logic [CHANNELS-1:0] start_r, start_nxt_s;
   logic [CHANNELS-1:0] flags_r, flags_nxt_s;
   logic [CNT_W-1:0]    run_r, run_nxt_s, run_inc_s;
   logic [CNT_W-1:0]    fail_r, fail_nxt_s, fail_inc_s;
   logic                busy_r, busy_nxt_s;
   logic                finished_r, finished_nxt_s;
   logic                pass_r, pass_nxt_s;

   // A done arriving on the final timeout cycle is folded in before the exit decision
   assign seen_s     = latch_r | done;
   assign run_inc_s  = (run_r == CNT_MAX) ? run_r : run_r + CNT_W'(1);
   assign fail_inc_s = (fail_r == CNT_MAX) ? fail_r : fail_r + CNT_W'(1);

   // Next-state and next-register-value logic
   always_comb begin
      state_nxt_s = state_r;
      latch_nxt_s = latch_r;
      timer_nxt_s = timer_r;
      gap_nxt_s   = gap_r;
      flags_nxt_s = flags_r;
      run_nxt_s   = run_r;
      fail_nxt_s  = fail_r;
      case (state_r)
         ST_IDLE: begin
            if (enable) begin
               state_nxt_s = ST_LAUNCH;
               run_nxt_s   = {CNT_W{1'b0}};
               fail_nxt_s  = {CNT_W{1'b0}};
               flags_nxt_s = {CHANNELS{1'b0}};
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            latch_nxt_s = {CHANNELS{1'b0}};
            timer_nxt_s = {TW{1'b0}};
            if (enable) state_nxt_s = ST_WAIT;
            else        state_nxt_s = ST_IDLE;
         end
         ST_WAIT: begin
            if (!enable) begin
               state_nxt_s = ST_IDLE;
            end else begin
               latch_nxt_s = seen_s;
               timer_nxt_s = timer_r + TW'(1);
               if ((&seen_s) || (timer_r == TIMER_LAST)) state_nxt_s = ST_CHECK;
               else                                      state_nxt_s = ST_WAIT;
            end
         end
         ST_CHECK: begin
            if (!enable) begin
               state_nxt_s = ST_IDLE;
            end else begin
               flags_nxt_s = ~latch_r;
               run_nxt_s   = run_inc_s;
               gap_nxt_s   = {GW{1'b0}};
               if (!(&latch_r)) fail_nxt_s = fail_inc_s;
               else             fail_nxt_s = fail_r;
               if (32'(run_inc_s) == RUNS) state_nxt_s = ST_FINISH;
               else if (GAP_CYCLES > 0)    state_nxt_s = ST_GAP;
               else                        state_nxt_s = ST_LAUNCH;
            end
         end
         ST_GAP: begin
            if (!enable)               state_nxt_s = ST_IDLE;
            else if (gap_r == GAP_LAST) state_nxt_s = ST_LAUNCH;
            else                        gap_nxt_s   = gap_r + GW'(1);
         end
         ST_FINISH: begin
            if (!enable) state_nxt_s = ST_IDLE;
            else         state_nxt_s = ST_FINISH;
         end
         default: state_nxt_s = ST_IDLE;
      endcase

      start_nxt_s    = ((state_r == ST_LAUNCH) && enable) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};
      busy_nxt_s     = (state_nxt_s == ST_LAUNCH) || (state_nxt_s == ST_WAIT) ||
                       (state_nxt_s == ST_CHECK)  || (state_nxt_s == ST_GAP);
      finished_nxt_s = (state_nxt_s == ST_FINISH);
      pass_nxt_s     = finished_nxt_s && (fail_nxt_s == {CNT_W{1'b0}});
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= ST_IDLE;
      else      state_r <= state_nxt_s;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         latch_r    <= {CHANNELS{1'b0}};
         timer_r    <= {TW{1'b0}};
         gap_r      <= {GW{1'b0}};
         start_r    <= {CHANNELS{1'b0}};
         flags_r    <= {CHANNELS{1'b0}};
         run_r      <= {CNT_W{1'b0}};
         fail_r     <= {CNT_W{1'b0}};
         busy_r     <= 1'b0;
         finished_r <= 1'b0;
         pass_r     <= 1'b0;
      end else begin
         latch_r    <= latch_nxt_s;
         timer_r    <= timer_nxt_s;
         gap_r      <= gap_nxt_s;
         start_r    <= start_nxt_s;
         flags_r    <= flags_nxt_s;
         run_r      <= run_nxt_s;
         fail_r     <= fail_nxt_s;
         busy_r     <= busy_nxt_s;
         finished_r <= finished_nxt_s;
         pass_r     <= pass_nxt_s;
      end
   end

   assign start         = start_r;
   assign busy          = busy_r;
   assign finished      = finished_r;
   assign pass          = pass_r;
   assign timeout_flags = flags_r;
   assign run_count     = run_r;
   assign fail_count    = fail_r;

endmodule
